// File: rtl/crossbar_buffered_if.sv
// Bundle of the crossbar data, routing-table and flow-control signals.
// The switch-control / input-buffer side is the master; the crossbar is the slave.
interface crossbar_buffered_if #(
   parameter int NPORT      = 5,
   parameter int FLIT_WIDTH = 16,
   parameter int SEL_WIDTH  = 3
);
   logic [NPORT-1:0]            data_av;
   logic [NPORT*FLIT_WIDTH-1:0] data_in_t;
   logic [NPORT*SEL_WIDTH-1:0]  tab_in_t;
   logic [NPORT*SEL_WIDTH-1:0]  tab_out_t;
   logic [NPORT-1:0]            free;
   logic [NPORT-1:0]            credit_i;
   logic [NPORT-1:0]            data_ack;
   logic [NPORT-1:0]            tx;
   logic [NPORT*FLIT_WIDTH-1:0] data_out_t;
   logic [NPORT-1:0]            out_empty;

   modport master (
      output data_av, data_in_t, tab_in_t, tab_out_t, free, credit_i,
      input  data_ack, tx, data_out_t, out_empty
   );

   modport slave (
      input  data_av, data_in_t, tab_in_t, tab_out_t, free, credit_i,
      output data_ack, tx, data_out_t, out_empty
   );
endinterface

// File: rtl/crossbar_buffered.sv
// NPORT x NPORT switch crossbar with a DEPTH-flit FIFO on every output.
// Input acks depend only on the routing tables, data_av and the registered
// FIFO occupancy, so downstream credit never reaches data_ack combinationally.
module crossbar_buffered #(
   parameter int NPORT      = 5,
   parameter int FLIT_WIDTH = 16,
   parameter int SEL_WIDTH  = 3,
   parameter int DEPTH      = 2
) (
   input logic                clock,
   input logic                reset,
   crossbar_buffered_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [SEL_WIDTH-1:0]  tab_in    [NPORT];
   logic [SEL_WIDTH-1:0]  tab_out   [NPORT];
   logic [FLIT_WIDTH-1:0] flit_in   [NPORT];
   logic [FLIT_WIDTH-1:0] push_flit [NPORT];
   logic [NPORT-1:0]      src_ok;
   logic [NPORT-1:0]      push;
   logic [NPORT-1:0]      pop;
   logic [NPORT-1:0]      tx;
   logic [NPORT-1:0]      ack;
   logic [NPORT-1:0]      empty;
   logic [NPORT*FLIT_WIDTH-1:0] dout;

   logic [CW-1:0]         count  [NPORT];
   logic [PW-1:0]         wr_ptr [NPORT];
   logic [PW-1:0]         rd_ptr [NPORT];
   logic [FLIT_WIDTH-1:0] mem    [NPORT][DEPTH];

   // Unflatten the packed routing tables and input flits
   always_comb begin
      for (int p = 0; p < NPORT; p++) begin
         tab_in[p]  = bus.tab_in_t[p*SEL_WIDTH +: SEL_WIDTH];
         tab_out[p] = bus.tab_out_t[p*SEL_WIDTH +: SEL_WIDTH];
         flit_in[p] = bus.data_in_t[p*FLIT_WIDTH +: FLIT_WIDTH];
      end
   end

   // Per output: pick the source named by tab_out; out-of-range entries match nothing
   always_comb begin
      src_ok = '0;
      push   = '0;
      for (int o = 0; o < NPORT; o++) begin
         push_flit[o] = '0;
         for (int j = 0; j < NPORT; j++) begin
            if (tab_out[o] == SEL_WIDTH'(j)) begin
               src_ok[o]    = ~bus.free[o] & bus.data_av[j];
               push_flit[o] = flit_in[j];
            end
         end
         // Full is judged on the registered count, so a same-cycle pop does not free a slot
         push[o] = src_ok[o] & (count[o] != FULL_CNT);
      end
   end

   // Ack an input only when both tables agree and its target output accepts the flit
   always_comb begin
      ack = '0;
      for (int i = 0; i < NPORT; i++) begin
         for (int o = 0; o < NPORT; o++) begin
            if (bus.data_av[i] && (tab_in[i] == SEL_WIDTH'(o)) &&
                (tab_out[o] == SEL_WIDTH'(i)) && push[o])
               ack[i] = 1'b1;
         end
      end
   end

   // Output side: FIFO head, valid, pop and empty status from registered state
   always_comb begin
      tx    = '0;
      pop   = '0;
      empty = '0;
      dout  = '0;
      for (int o = 0; o < NPORT; o++) begin
         tx[o]    = (count[o] != '0);
         empty[o] = (count[o] == '0);
         pop[o]   = tx[o] & bus.credit_i[o];
         if (tx[o])
            dout[o*FLIT_WIDTH +: FLIT_WIDTH] = mem[o][rd_ptr[o]];
      end
   end

   assign bus.data_ack   = ack;
   assign bus.tx         = tx;
   assign bus.data_out_t = dout;
   assign bus.out_empty  = empty;

   // FIFO pointers and occupancy; reset drops anything buffered
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int o = 0; o < NPORT; o++) begin
            count[o]  <= '0;
            wr_ptr[o] <= '0;
            rd_ptr[o] <= '0;
         end
      end else begin
         for (int o = 0; o < NPORT; o++) begin
            if (push[o])
               wr_ptr[o] <= wr_ptr[o] + PW'(1);
            if (pop[o])
               rd_ptr[o] <= rd_ptr[o] + PW'(1);
            case ({push[o], pop[o]})
               2'b10:   count[o] <= count[o] + CW'(1);
               2'b01:   count[o] <= count[o] - CW'(1);
               default: count[o] <= count[o];
            endcase
         end
      end
   end

   // Flit storage; contents are masked by count, so it needs no reset
   always_ff @(posedge clock) begin
      for (int o = 0; o < NPORT; o++) begin
         if (push[o])
            mem[o][wr_ptr[o]] <= push_flit[o];
      end
   end
endmodule
